// File: rtl/bcd_updown_mod.sv
// Two-digit BCD up/down counter, modulus MOD (2..100), with wrap/saturate and load.
// Define BCD_LOAD_CHECK_EN to reject illegal load values (load MOD-1, pulse err).
module bcd_updown_mod #(
  parameter int MOD = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       up,
  input  logic       wrap,
  input  logic       load,
  input  logic [3:0] tens_in,
  input  logic [3:0] ones_in,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       carry,
  output logic       tc,
  output logic       zero,
  output logic       err
);

  localparam logic [3:0] MAX_T = 4'((MOD - 1) / 10);
  localparam logic [3:0] MAX_O = 4'((MOD - 1) % 10);

  logic w_at_max;

  assign w_at_max = (tens == MAX_T) && (ones == MAX_O);
  assign zero     = (tens == 4'd0) && (ones == 4'd0);
  assign tc       = up ? w_at_max : zero;

`ifdef BCD_LOAD_CHECK_EN
  localparam logic [7:0] MOD_V = 8'(MOD);
  logic [7:0] w_load_val;
  logic       w_load_bad;

  assign w_load_val = ({4'd0, tens_in} * 8'd10) + {4'd0, ones_in};
  assign w_load_bad = (tens_in > 4'd9) || (ones_in > 4'd9) || (w_load_val >= MOD_V);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tens  <= 4'd0;
      ones  <= 4'd0;
      carry <= 1'b0;
      err   <= 1'b0;
    end else begin
      carry <= 1'b0;
      err   <= 1'b0;
      if (load) begin
`ifdef BCD_LOAD_CHECK_EN
        if (w_load_bad) begin
          tens <= MAX_T;
          ones <= MAX_O;
          err  <= 1'b1;
        end else begin
          tens <= tens_in;
          ones <= ones_in;
        end
`else
        tens <= tens_in;
        ones <= ones_in;
`endif
      end else if (en) begin
        if (up) begin
          if (w_at_max) begin
            if (wrap) begin
              tens  <= 4'd0;
              ones  <= 4'd0;
              carry <= 1'b1;
            end
          end else if (ones >= 4'd9) begin
            ones <= 4'd0;
            tens <= tens + 4'd1;
          end else begin
            ones <= ones + 4'd1;
          end
        end else begin
          // ones first, then borrow from tens, then wrap/saturate at 00
          if (ones != 4'd0) begin
            ones <= ones - 4'd1;
          end else if (tens != 4'd0) begin
            ones <= 4'd9;
            tens <= tens - 4'd1;
          end else if (wrap) begin
            tens  <= MAX_T;
            ones  <= MAX_O;
            carry <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_updown_mod.sv
// Bench for bcd_updown_mod (MOD=60): vector table, corner sequences, random vs. integer model.
module tb_bcd_updown_mod;
  localparam int MOD = 60;

  logic       clk = 1'b0;
  logic       rst, en, up, wrap, load;
  logic [3:0] tens_in, ones_in;
  logic [3:0] tens, ones;
  logic       carry, tc, zero, err;

  int n_tests = 0;
  int n_fail  = 0;

  // integer-valued reference state
  int m_cnt;
  bit m_carry, m_err;

  bcd_updown_mod #(.MOD(MOD)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .wrap(wrap), .load(load),
    .tens_in(tens_in), .ones_in(ones_in),
    .tens(tens), .ones(ones), .carry(carry), .tc(tc), .zero(zero), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       ld, e, u, w;
    bit [3:0] ti, oi;
    int       et, eo;
    bit       ec;
  } vec_t;

  task automatic chk(input string nm, input int et, input int eo, input bit ec,
                     input bit ee, input bit etc, input bit ez);
    n_tests++;
    if (tens !== 4'(et) || ones !== 4'(eo) || carry !== ec || err !== ee ||
        tc !== etc || zero !== ez) begin
      n_fail++;
      $display("FAIL %s: got %0d%0d c=%b e=%b tc=%b z=%b, want %0d%0d c=%b e=%b tc=%b z=%b",
               nm, tens, ones, carry, err, tc, zero, et, eo, ec, ee, etc, ez);
    end
  endtask

  function automatic void model_step();
    int v;
    m_carry = 0;
    m_err   = 0;
    if (load) begin
      v = int'(tens_in) * 10 + int'(ones_in);
`ifdef BCD_LOAD_CHECK_EN
      if (tens_in > 9 || ones_in > 9 || v >= MOD) begin
        v     = MOD - 1;
        m_err = 1;
      end
`endif
      m_cnt = v;
    end else if (en) begin
      if (up) begin
        if (m_cnt == MOD - 1) begin
          if (wrap) begin m_cnt = 0; m_carry = 1; end
        end else m_cnt = m_cnt + 1;
      end else begin
        if (m_cnt == 0) begin
          if (wrap) begin m_cnt = MOD - 1; m_carry = 1; end
        end else m_cnt = m_cnt - 1;
      end
    end
  endfunction

  task automatic chk_model(input string nm);
    bit z;
    z = (m_cnt == 0);
    chk(nm, m_cnt / 10, m_cnt % 10, m_carry, m_err, up ? (m_cnt == MOD - 1) : z, z);
  endtask

  task automatic drive(input bit ld, input bit e, input bit u, input bit w,
                       input bit [3:0] ti, input bit [3:0] oi);
    load = ld; en = e; up = u; wrap = w; tens_in = ti; ones_in = oi;
  endtask

  // one clock with the model tracking it; sample 1 time unit after the edge
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 1, 0, 0, 0);
    rst = 1'b1;
    m_cnt = 0; m_carry = 0; m_err = 0;
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];

  initial begin
    rst = 1'b0;
    drive(0, 0, 1, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("reset_async", 0, 0, 0, 0, 0, 1);
    do_reset();
    chk("reset_state", 0, 0, 0, 0, 0, 1);

    // {load, en, up, wrap, tens_in, ones_in, exp_tens, exp_ones, exp_carry}
    tbl = '{
      '{1,0,0,1,0,0, 0,0,0},  // load 00
      '{0,1,0,1,0,0, 5,9,1},  // borrow wrap 00 -> 59
      '{0,1,0,1,0,0, 5,8,0},
      '{1,1,1,1,4,2, 4,2,0},  // load beats en
      '{0,1,1,1,0,0, 4,3,0},
      '{0,1,0,1,0,0, 4,2,0},
      '{0,1,1,1,0,0, 4,3,0},
      '{1,0,0,0,0,1, 0,1,0},
      '{0,1,0,0,0,0, 0,0,0},  // saturate low
      '{0,1,0,0,0,0, 0,0,0},
      '{0,1,0,0,0,0, 0,0,0},
      '{1,0,1,1,5,7, 5,7,0},
      '{0,1,1,1,0,0, 5,8,0},
      '{0,1,1,1,0,0, 5,9,0},
      '{0,1,1,1,0,0, 0,0,1},  // carry wrap 59 -> 00
      '{0,1,1,1,0,0, 0,1,0},
      '{0,0,1,1,0,0, 0,1,0},  // idle
      '{1,1,1,0,5,9, 5,9,0},
      '{0,1,1,0,0,0, 5,9,0},  // saturate high
      '{0,1,1,1,0,0, 0,0,1},
      '{1,0,1,1,0,9, 0,9,0},
      '{0,1,1,1,0,0, 1,0,0},  // ones 9 -> tens step
      '{0,1,0,1,0,0, 0,9,0}   // borrow from tens
    };
    for (int i = 0; i < tbl.size(); i++) begin
      bit z;
      drive(tbl[i].ld, tbl[i].e, tbl[i].u, tbl[i].w, tbl[i].ti, tbl[i].oi);
      @(posedge clk);
      #1;
      z = (tbl[i].et == 0 && tbl[i].eo == 0);
      chk($sformatf("vec%0d", i), tbl[i].et, tbl[i].eo, tbl[i].ec, 1'b0,
          tbl[i].u ? (tbl[i].et == 5 && tbl[i].eo == 9) : z, z);
    end

    // async reset between edges at 37, then first enabled step gives 01
    do_reset();
    drive(1, 0, 1, 1, 3, 7); cyc();
    chk_model("load37");
    drive(0, 1, 1, 1, 0, 0);
    #3 rst = 1'b1;
    #2;
    chk("rst_mid_cycle", 0, 0, 0, 0, 0, 1);
    @(posedge clk);
    #3 rst = 1'b0;
    m_cnt = 0; m_carry = 0; m_err = 0;
    cyc();
    chk_model("first_after_rst");
    if (m_cnt != 1) begin n_tests++; end

    // reset across a pending load discards it
    drive(1, 0, 1, 1, 4, 5);
    rst = 1'b1;
    @(posedge clk);
    #3 rst = 1'b0;
    m_cnt = 0; m_carry = 0; m_err = 0;
    drive(0, 0, 1, 1, 0, 0);
    cyc();
    chk_model("rst_over_load");

`ifdef BCD_LOAD_CHECK_EN
    drive(1, 0, 1, 1, 7, 10); cyc(); chk("bad_digit", 5, 9, 0, 1, 1, 0);
    drive(0, 0, 1, 1, 0, 0);  cyc(); chk("err_one_cycle", 5, 9, 0, 0, 1, 0);
    drive(1, 0, 1, 1, 7, 5);  cyc(); chk("bad_range", 5, 9, 0, 1, 1, 0);
    drive(1, 0, 1, 1, 6, 0);  cyc(); chk("bad_eq_mod", 5, 9, 0, 1, 1, 0);
    drive(1, 0, 1, 1, 3, 5);  cyc(); chk("good_load", 3, 5, 0, 0, 0, 0);
`else
    drive(1, 0, 1, 1, 7, 5);  cyc(); chk("verbatim_load", 7, 5, 0, 0, 0, 0);
    drive(1, 0, 1, 1, 3, 5);  cyc(); chk("recover_load", 3, 5, 0, 0, 0, 0);
`endif

    // randomized traffic vs. integer model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit       ld;
      bit [3:0] ti, oi;
      ld = ($urandom_range(0, 9) == 0);
`ifdef BCD_LOAD_CHECK_EN
      ti = 4'($urandom_range(0, 15));
      oi = 4'($urandom_range(0, 15));
`else
      ti = 4'($urandom_range(0, 5));
      oi = 4'($urandom_range(0, 9));
`endif
      drive(ld, ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), ti, oi);
      cyc();
      chk_model($sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
